// File: rtl/pcihellocore_hexdecode.sv
`default_nettype none
// ============================================================================
// Module      : pcihellocore_hexdecode
// Description : Drives NUM_DIGITS active-low 7-segment displays from the hex
//               PIO port value. One shared nibble decoder is time-multiplexed
//               by a scan FSM. Supports leading-zero blanking and blinking,
//               and commits all digits on one edge so no mixed value is shown.
// Revision    : 1.0 - initial release
// ============================================================================
module pcihellocore_hexdecode #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] in_port,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    update_pulse,
  output logic                    busy
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] in_q;
  logic                    lz_q;
  logic                    in_valid;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    lz_shadow;
  logic                    dirty;
  logic [IDX_W-1:0]        idx;
  logic                    lz_run;
  logic [7*NUM_DIGITS-1:0] seg_buf;
  logic [7*NUM_DIGITS-1:0] hex_reg;
  logic [CNT_W-1:0]        blink_cnt;
  logic                    blink_phase;
  logic [3:0]              scan_nib;

  // Active-low gfedcba pattern for one hex nibble
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Nibble currently addressed by the scan index
  assign scan_nib = shadow[4*idx +: 4];

  // Input sampling stage; in_valid keeps the FSM from acting on the
  // stale sample during the first cycle after reset is released
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q     <= '0;
      lz_q     <= 1'b0;
      in_valid <= 1'b0;
    end else begin
      in_q     <= in_port;
      lz_q     <= blank_lz;
      in_valid <= 1'b1;
    end
  end

  // Scan FSM: snapshot in IDLE, decode one digit per cycle, commit atomically
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hex_reg      <= '1;
      seg_buf      <= '1;
      update_pulse <= 1'b0;
      dirty        <= 1'b1;
      shadow       <= '0;
      lz_shadow    <= 1'b0;
      idx          <= '0;
      lz_run       <= 1'b1;
    end else begin
      update_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && (dirty || (in_q != shadow) || (lz_q != lz_shadow))) begin
            shadow    <= in_q;
            lz_shadow <= lz_q;
            dirty     <= 1'b0;
            idx       <= IDX_W'(NUM_DIGITS - 1);
            lz_run    <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          // Digit 0 is never blanked so a zero value still shows "0"
          if (lz_shadow && lz_run && (scan_nib == 4'h0) && (idx != '0)) begin
            seg_buf[7*idx +: 7] <= 7'h7F;
          end else begin
            seg_buf[7*idx +: 7] <= seg_decode(scan_nib);
            lz_run              <= 1'b0;
          end
          if (idx == '0) begin
            state <= COMMIT;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        COMMIT: begin
          hex_reg      <= seg_buf;
          update_pulse <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Blink half-period counter; parked at zero while blinking is disabled
  always_ff @(posedge clk) begin
    if (reset || !blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign hex_out = blink_phase ? '1 : hex_reg;
  assign busy    = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/pcihellocore_hexdecode.md
Name: pcihellocore_hexdecode

Overview:
Downstream consumer of the 32-bit hex PIO output port. Converts the 8 nibbles of the port value into active-low 7-segment patterns for 8 static displays. A single shared decoder is time-multiplexed through a scan FSM. Adds optional leading-zero blanking and a blink function, and commits all digits atomically so displays never show a mixed old/new value.

Parameters:
NUM_DIGITS, 8, number of nibbles/displays decoded; in_port width = 4*NUM_DIGITS.
BLINK_DIV, 25000000, clk cycles per blink half-period; minimum 1.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
in_port  input  4*NUM_DIGITS  value from the hex PIO out_port.
blank_lz  input  1  1 = blank leading zero digits (digit 0 always shown).
blink_en  input  1  1 = blink all displays at BLINK_DIV rate.
hex_out  output  7*NUM_DIGITS  segments, active-low, digit k at [7k+6:7k], bit order gfedcba (bit6 = g).
update_pulse  output  1  one-cycle strobe when hex_out takes a new value.
busy  output  1  high while FSM is not IDLE.

Behaviour:
- Reset (sync, has priority over everything):
  - hex_reg = all ones (blank); update_pulse = 0; busy = 0.
  - blink counter = 0; blink_phase = 0; state = IDLE; dirty = 1.
- Input stage: in_q <= in_port and lz_q <= blank_lz every cycle (1 register stage).
- FSM states: IDLE, SCAN, COMMIT.
- IDLE: if dirty, or in_q != shadow, or lz_q != lz_shadow:
  - shadow <= in_q; lz_shadow <= lz_q; dirty <= 0.
  - idx <= NUM_DIGITS-1; lz_run <= 1; go SCAN.
- SCAN: one digit per cycle, MSB digit first.
  - Decode nibble = shadow[4*idx+3:4*idx].
  - If lz_shadow && lz_run && nibble==0 && idx!=0: seg_buf[idx] = 7'h7F.
  - Otherwise seg_buf[idx] = decode(nibble) and lz_run <= 0.
  - At idx==0 go COMMIT; else idx <= idx-1.
- COMMIT: hex_reg <= seg_buf (all digits in the same edge); update_pulse = 1 for exactly this one cycle; go IDLE.
- Latency: in_port changes before edge 1 -> hex_out and update_pulse change after edge NUM_DIGITS+3 (edge 11 for 8 digits). busy is high for NUM_DIGITS+1 cycles.
- Input changes during SCAN/COMMIT are ignored until IDLE, then recompared, so the latest value is always displayed. Intermediate values may be skipped. Mixed digits are never displayed.
- Decode table (hex, active-low):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Blink:
  - blink_en=0: counter and blink_phase held at 0.
  - blink_en=1: counter counts 0..BLINK_DIV-1; on wrap it returns to 0 and toggles blink_phase.
  - hex_out = hex_reg when blink_phase=0; all ones when blink_phase=1.
  - hex_out is a function of registers only, with no combinational path from inputs.
  - Blink does not affect update_pulse or the FSM.
- Reset mid-scan: in-flight scan is discarded, outputs blank, dirty=1. A full refresh of in_port starts on the second cycle after reset deasserts.

Test Plan:
1. Hold reset 3 cycles, in_port=0, blank_lz=0 -> hex_out all ones during reset. One update_pulse at edge 11 after release, then all digits 0x40.
2. in_port=0x0123ABCD, blank_lz=0 -> after edge 11: digits 7..0 = 40,79,24,30,08,03,46,21. busy high 9 cycles; exactly one update_pulse.
3. blank_lz=1, in_port=0x000000A0 -> digits 7..2 = 7F, digit1 = 08, digit0 = 40. Then in_port=0 -> only digit0 = 40, others 7F.
4. in_port=0x11111111, then 0x22222222 three cycles later -> hex_out goes to all-79, then all-24, with two update_pulses. No cycle shows mixed digits.
5. BLINK_DIV=4, blink_en=1, value 0x12345678 -> hex_out alternates 4 cycles all-ones / 4 cycles pattern. Drop blink_en -> steady pattern the next cycle.
6. Assert reset at edge 5 of a scan -> hex_out blank and update_pulse 0 during reset. After release, a full refresh completes with the current in_port.
